// File: rtl/arb_pixel_fifo.sv
// Show-ahead FIFO between the two-slave arbiter and the processing engine.
// Latency: a word pushed at edge N is on rd_* with rd_valid=1 right after edge N.
// Backpressure: fifo_full (count == DEPTH) stalls the arbiter; writes while full are dropped and flagged.
module arb_pixel_fifo #(
  parameter int DW        = 32,
  parameter int DEPTH     = 16,  // power of 2, >= 4
  parameter int AF_MARGIN = 2    // 1 .. DEPTH-1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 wr_mode,
  input  logic [DW-1:0]              wr_data,
  input  logic [7:0]                 wr_proc_val,
  input  logic                       wr_valid,
  output logic                       fifo_full,
  output logic                       fifo_afull,
  input  logic                       flush,
  output logic [1:0]                 rd_mode,
  output logic [DW-1:0]              rd_data,
  output logic [7:0]                 rd_proc_val,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf_err,
  output logic                       mode_chg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [1:0]    mode;
    logic [7:0]    proc_val;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    last_mode;
  logic          wr_req;
  logic          push;
  logic          pop;
  entry_t        head;

  // Flags come straight from the registered count, so they lag a push/pop by one cycle.
  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_afull = (count >= CW'(DEPTH - AF_MARGIN));
  assign rd_valid   = (count != '0);

  // Mode 0 means "no word"; flush wins over any concurrent traffic.
  assign wr_req = wr_valid && (wr_mode != 2'd0) && !flush;
  assign push   = wr_req && !fifo_full;
  assign pop    = rd_valid && rd_ready && !flush;

  // Head entry is shown continuously; storage is reset so the payload reads 0 out of reset.
  assign head        = mem[rd_ptr];
  assign rd_mode     = head.mode;
  assign rd_proc_val = head.proc_val;
  assign rd_data     = head.data;

  // Pulses in the pop cycle when the popped mode differs from the last popped one.
  assign mode_chg = pop && (rd_mode != last_mode);

  // Storage write; write and read never touch the same entry in one cycle since count gates both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= '{mode: wr_mode, proc_val: wr_proc_val, data: wr_data};
    end
  end

  // Pointers, occupancy and last popped mode; flush clears everything in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_mode <= 2'd0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_mode <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        last_mode <= rd_mode;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Sticky overflow: a real write arriving while full, cleared only by reset or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (flush) begin
      ovf_err <= 1'b0;
    end else if (wr_req && fifo_full) begin
      ovf_err <= 1'b1;
    end
  end

endmodule

// File: doc/arb_pixel_fifo.md
Name: arb_pixel_fifo

Overview:
- Buffering stage directly downstream of the two-slave arbiter.
- Captures each arbitrated word together with its mode and processing value, and presents the words in order to the processing engine with a valid/ready handshake.
- Drives the fifo_full back-pressure the arbiter uses to drop both slave readies.
- Also provides an almost-full flag, overflow detection and mode-change marking for the engine.

Parameters:
- DW, 32, data width of the pixel word.
- DEPTH, 16, number of entries. Must be a power of 2 and at least 4.
- AF_MARGIN, 2, fifo_afull asserts when count >= DEPTH-AF_MARGIN. Legal range is 1..DEPTH-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_mode  in  2  arbiter slvx_mode. 0 = idle/no mode.
- wr_data  in  DW  arbiter slvx_data.
- wr_proc_val  in  8  arbiter slvx_proc_val.
- wr_valid  in  1  arbiter slvx_data_valid.
- fifo_full  out  1  count == DEPTH; to arbiter.
- fifo_afull  out  1  count >= DEPTH-AF_MARGIN.
- flush  in  1  synchronous clear, e.g. on master complete.
- rd_mode  out  2  mode of head entry.
- rd_data  out  DW  data of head entry.
- rd_proc_val  out  8  proc value of head entry.
- rd_valid  out  1  head entry present.
- rd_ready  in  1  engine accepts head.
- count  out  $clog2(DEPTH)+1  current occupancy.
- ovf_err  out  1  sticky; write attempted while full.
- mode_chg  out  1  one-cycle pulse on a pop whose rd_mode differs from the previously popped mode.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset:
  - Pointers, count and last_mode are 0.
  - All outputs are 0, including fifo_full, fifo_afull, rd_valid, rd_* payload, ovf_err and mode_chg.
- Storage: entry = {mode[1:0], proc_val[7:0], data[DW-1:0]}. Write and read pointers are log2(DEPTH) bits and wrap naturally at DEPTH-1 → 0.
- Push condition: wr_valid && wr_mode != 0 && !fifo_full && !flush.
  - wr_valid with wr_mode == 0 is ignored silently.
- Overflow: wr_valid && wr_mode != 0 && fifo_full && !flush.
  - The word is dropped and ovf_err is set.
  - ovf_err stays set until rst or flush.
- Pop condition: rd_valid && rd_ready && !flush.
- Show-ahead timing:
  - rd_valid = (count != 0). rd_* always shows the entry at the read pointer.
  - A word pushed at edge N is visible on rd_* with rd_valid=1 after edge N (zero-wait fall-through).
  - There is no same-cycle bypass: push and pop cannot involve the same entry in one cycle.
- Count update: count <= count + push - pop. Simultaneous push and pop leaves count unchanged.
- Full and empty boundaries:
  - fifo_full is derived from the current count, so a push arriving in the cycle the FIFO is full is rejected even if a pop occurs that cycle.
  - Pop while empty cannot occur, because rd_valid = 0.
- Flags: fifo_full and fifo_afull are combinational from the registered count, so they update in the cycle after the push or pop.
- mode_chg:
  - Asserted for exactly the cycle in which a pop occurs with rd_mode != last_mode. last_mode is updated to rd_mode on every pop.
  - Since last_mode resets to 0, the first pop after reset or flush always pulses.
- Flush:
  - At the edge where flush = 1: pointers, count, last_mode and ovf_err are cleared.
  - Any simultaneous push or pop is discarded.
  - rd_valid = 0 from the following cycle.
- Reset mid-operation: all contents are discarded immediately and asynchronously. No partial state survives.

Test Plan:
- Reset: assert rst mid-traffic with count=5 → count=0, rd_valid=0, fifo_full=0, ovf_err=0, with no clock edge required.
- Basic ordering, DEPTH=16:
  - Push 3 words (mode=1, proc_val 0x10/0x11/0x12, data 0xA0..0xA2) with rd_ready=0 → count=3.
  - Then set rd_ready=1 → data pops in order 0xA0, 0xA1, 0xA2.
  - mode_chg pulses only on the first pop.
- Fill and overflow:
  - Push 16 words → fifo_full=1, and fifo_afull=1 already from count=14.
  - A 17th push is dropped, ovf_err=1, count stays 16.
- Simultaneous push and pop at full: count=16, wr_valid=1 and rd_ready=1 for one cycle → pop happens, push is rejected, count=15, ovf_err=1.
- Wrap-around with mode switch:
  - Stream 40 words with continuous push and pop, mode=1 for words 0-19 and mode=2 for words 20-39.
  - All 40 words emerge in order, count never exceeds 2.
  - mode_chg pulses on pop 0 and pop 20 only.
- Flush: with count=7 and ovf_err=1, pulse flush together with wr_valid=1 → next cycle count=0, ovf_err=0, rd_valid=0, and the concurrent word is not stored.
